writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Parametrised writeback stage for the next core revision. It accepts completed results from `NUM_SRC` independent execution pipes, buffers each pipe in a small FIFO, and formats load data (byte/half/word, signed/unsigned). It then round-robin arbitrates the single register-file write port. It sits between the memory-access/execute pipes and the register file, and replaces the single-source writeback of the in-order pipe.

## Interface
Parameters:
- `NUM_SRC`, 2, number of result sources (2..8); source 0 is the ALU pipe, source 1 the load pipe.
- `FIFO_DEPTH`, 2, entries per source FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `src_valid`  in  NUM_SRC  result valid per source.
- `src_ready`  out  NUM_SRC  source FIFO can accept.
- `src_pc`  in  NUM_SRC×32  instruction PC.
- `src_rd`  in  NUM_SRC×5  destination register.
- `src_we`  in  NUM_SRC  instruction writes rd.
- `src_is_load`  in  NUM_SRC  result is a load.
- `src_funct3`  in  NUM_SRC×3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `src_alu_result`  in  NUM_SRC×32  ALU result, or effective address for loads.
- `src_mem_data`  in  NUM_SRC×32  raw aligned memory word for loads.
- `rf_we`  out  1  register write enable.
- `rf_rd`  out  5  register address.
- `rf_data`  out  32  write data.
- `rf_pc`  out  32  PC of the written instruction.
- `busy`  out  1  any FIFO non-empty or `rf_we` high.

## Operation
- Handshake: an entry transfers on an edge where `src_valid[i] && src_ready[i]`. `src_ready[i]` = FIFO i not full. Readiness does not depend on a same-cycle dequeue: a full FIFO stays not-ready for that cycle.
- Drop filter: a transfer with `src_we=0` or `src_rd=0` is accepted but not enqueued. It never reaches `rf_*`.
- Data formatting at enqueue. The stored data is computed combinationally from the inputs:
  - Non-load: data = `src_alu_result`.
  - Load, byte offset `o = alu_result[1:0]`:
    - LB/LBU: byte `o`, sign-/zero-extended.
    - LH/LHU: halfword `o[1]`, sign-/zero-extended; `o[0]` is ignored.
    - LW: full word.
  - Other funct3 values produce data 0.
- FIFO entry = {pc, rd, data}. Pointers are log2(FIFO_DEPTH)+1 bits, and full/empty is decided by the MSB compare. Pointers wrap modulo 2·FIFO_DEPTH.
- Arbiter:
  - Round-robin over non-empty FIFOs, starting from pointer `rr`.
  - Exactly one head is dequeued per cycle when any FIFO is non-empty.
  - After a grant to source g, `rr` becomes (g+1) mod NUM_SRC. With no grant, `rr` holds.
- Output register: on a grant, `rf_we←1` and `rf_rd/rf_data/rf_pc` load the head entry. With no grant, `rf_we←0` and the other outputs hold their values.
- Simultaneous enqueue and dequeue on the same FIFO is legal. The occupancy stays unchanged.
- Reset (asynchronous, any time):
  - All FIFOs empty, `rr=0`.
  - `rf_we=0`, `rf_rd=0`, `rf_data=0`, `rf_pc=0`.
  - `src_ready` all 1 (combinational from empty), `busy=0`.
  - In-flight entries are discarded.

## Timing
- Latency: transfer at edge E0 → head visible, grant in cycle E0..E1 → `rf_we=1` during the cycle after E1. That is 2 edges minimum.
- Throughput: one register write per cycle total across all sources.
- Worst-case wait for a head entry: NUM_SRC−1 grants to other sources.
- `src_ready` is a function of FIFO state only; there is no combinational path from `src_valid`.
- `busy` is combinational from FIFO state and `rf_we`.

## Configuration
- `WRITEBACK_TRACE_EN` defined:
  - On every edge where `rf_we` is being loaded with 1, the block prints a `$display` line: `0xPPPP: xRR = 0xDDDDDDDD`.
  - For loads it appends ` <- mem[0xAAAAAAAA]`. This requires the entry to also store `is_load` and the address.
- `WRITEBACK_TRACE_EN` undefined: no display statements, and no extra entry fields. Functional behaviour is identical.

## Test plan
- Reset mid-stream: with 2 entries queued in source 0, pulse `rst_n` low asynchronously. Required: `rf_we=0` immediately, `src_ready=2'b11`, `busy=0`, and no stale write appears after release.
- Single ALU result: src0 pc=0x100, rd=5, alu=0x1234_5678. Required: `rf_we=1`, rd=5, data=0x12345678, pc=0x100, exactly 2 edges after the transfer, for exactly one cycle.
- Load formatting on src1, mem_data=0x80FF_7F01:
  - LB off=2 → 0xFFFFFFFF.
  - LBU off=3 → 0x00000080.
  - LH off=2 → 0xFFFF80FF.
  - LHU off=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Round-robin: both sources push 4 results back-to-back (FIFO_DEPTH=2). Required:
  - Writes alternate src0, src1, src0, ….
  - `src_ready` drops while a FIFO is full.
  - All 8 writes appear in per-source order, with no loss or duplication.
- Drop filter: rd=0 with we=1, and rd=7 with we=0. Required: both are accepted (`src_ready` stays 1), `rf_we` never asserts, and `busy` stays 0.
- Full boundary: hold a FIFO full while the arbiter dequeues it and the source asserts valid. Required: no transfer on the full cycle, and a transfer accepted on the next cycle.

Source files
------------

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: per-source result FIFOs, load formatting and round-robin register-file write port.
// Define WRITEBACK_TRACE_EN to print a trace line for every register write.
module writeback_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    src_valid,
    output logic [NUM_SRC-1:0]    src_ready,
    input  logic [NUM_SRC*32-1:0] src_pc,
    input  logic [NUM_SRC*5-1:0]  src_rd,
    input  logic [NUM_SRC-1:0]    src_we,
    input  logic [NUM_SRC-1:0]    src_is_load,
    input  logic [NUM_SRC*3-1:0]  src_funct3,
    input  logic [NUM_SRC*32-1:0] src_alu_result,
    input  logic [NUM_SRC*32-1:0] src_mem_data,
    output logic                  rf_we,
    output logic [4:0]            rf_rd,
    output logic [31:0]           rf_data,
    output logic [31:0]           rf_pc,
    output logic                  busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
`ifdef WRITEBACK_TRACE_EN
    localparam int EW = 102;
`else
    localparam int EW = 69;
`endif
    localparam logic [SW-1:0] LAST = SW'(NUM_SRC - 1);

    logic [NUM_SRC-1:0][PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [EW-1:0]              mem_q [NUM_SRC][FIFO_DEPTH];
    logic [EW-1:0]              mem_d [NUM_SRC][FIFO_DEPTH];
    logic [NUM_SRC-1:0][EW-1:0] entry;
    logic [NUM_SRC-1:0]         empty, push, gnt;
    logic [SW-1:0]              rr_q, rr_d, g;
    logic                       any;
    logic [EW-1:0]              head;
    logic                       rf_we_q, rf_we_d;
    logic [4:0]                 rf_rd_q, rf_rd_d;
    logic [31:0]                rf_data_q, rf_data_d, rf_pc_q, rf_pc_d;

    function automatic logic [31:0] fmt(input logic ld, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] m);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(m >> {a[1:0], 3'b000});
        h = a[1] ? m[31:16] : m[15:0];
        return !ld        ? a :
               f3 == 3'b000 ? {{24{b[7]}}, b} :
               f3 == 3'b001 ? {{16{h[15]}}, h} :
               f3 == 3'b010 ? m :
               f3 == 3'b100 ? {24'b0, b} :
               f3 == 3'b101 ? {16'b0, h} : 32'b0;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            empty[i]     = wp_q[i] == rp_q[i];
            src_ready[i] = !(wp_q[i][AW-1:0] == rp_q[i][AW-1:0] && wp_q[i][PW-1] != rp_q[i][PW-1]);
            push[i]      = src_valid[i] && src_ready[i] && src_we[i] && src_rd[i*5 +: 5] != 5'd0;
`ifdef WRITEBACK_TRACE_EN
            entry[i] = {src_is_load[i], src_alu_result[i*32 +: 32], src_pc[i*32 +: 32], src_rd[i*5 +: 5],
                        fmt(src_is_load[i], src_funct3[i*3 +: 3], src_alu_result[i*32 +: 32], src_mem_data[i*32 +: 32])};
`else
            entry[i] = {src_pc[i*32 +: 32], src_rd[i*5 +: 5],
                        fmt(src_is_load[i], src_funct3[i*3 +: 3], src_alu_result[i*32 +: 32], src_mem_data[i*32 +: 32])};
`endif
        end
        // first non-empty FIFO at or after rr wins
        any = 1'b0;
        g   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!any && !empty[(int'(rr_q) + k) % NUM_SRC]) begin
                any = 1'b1;
                g   = SW'((int'(rr_q) + k) % NUM_SRC);
            end
        end
        gnt  = {{(NUM_SRC-1){1'b0}}, any} << g;
        head = mem_q[g][rp_q[g][AW-1:0]];
        mem_d = mem_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            wp_d[i] = wp_q[i] + PW'(push[i]);
            rp_d[i] = rp_q[i] + PW'(gnt[i]);
            if (push[i]) mem_d[i][wp_q[i][AW-1:0]] = entry[i];
        end
        rr_d      = any ? (g == LAST ? '0 : g + 1'b1) : rr_q;
        rf_we_d   = any;
        rf_rd_d   = any ? head[36:32] : rf_rd_q;
        rf_data_d = any ? head[31:0]  : rf_data_q;
        rf_pc_d   = any ? head[68:37] : rf_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q      <= '0;
            rp_q      <= '0;
            rr_q      <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            rf_pc_q   <= '0;
            for (int i = 0; i < NUM_SRC; i++)
                for (int j = 0; j < FIFO_DEPTH; j++)
                    mem_q[i][j] <= '0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            rr_q      <= rr_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            rf_pc_q   <= rf_pc_d;
            mem_q     <= mem_d;
`ifdef WRITEBACK_TRACE_EN
            if (any && head[101])
                $display("0x%04h: x%02d = 0x%08h <- mem[0x%08h]", head[52:37], head[36:32], head[31:0], head[100:69]);
            else if (any)
                $display("0x%04h: x%02d = 0x%08h", head[52:37], head[36:32], head[31:0]);
`endif
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_rd   = rf_rd_q;
    assign rf_data = rf_data_q;
    assign rf_pc   = rf_pc_q;
    assign busy    = any || rf_we_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed checks of reset, ALU/load writeback, drop filter, full boundary and round-robin order.
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  src_valid = '0, src_ready, src_we = '0, src_is_load = '0;
    logic [63:0] src_pc = '0, src_alu_result = '0, src_mem_data = '0;
    logic [9:0]  src_rd = '0;
    logic [5:0]  src_funct3 = '0;
    logic        rf_we, busy;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data, rf_pc;
    int          checks = 0, errors = 0;

    writeback_arbiter dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
        .src_pc(src_pc), .src_rd(src_rd), .src_we(src_we), .src_is_load(src_is_load),
        .src_funct3(src_funct3), .src_alu_result(src_alu_result), .src_mem_data(src_mem_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .rf_pc(rf_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic we, input logic ld, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] mem);
        src_valid[i]             = v;
        src_pc[i*32 +: 32]       = pc;
        src_rd[i*5 +: 5]         = rd;
        src_we[i]                = we;
        src_is_load[i]           = ld;
        src_funct3[i*3 +: 3]     = f3;
        src_alu_result[i*32 +: 32] = alu;
        src_mem_data[i*32 +: 32] = mem;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_off [5] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    logic [4:0]  rr_rd  [8] = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    logic [1:0]  rr_rdy [7] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};

    initial begin
        int  i0, i1, n;
        logic a0, a1;
        repeat (2) tick();
        chk("rst_we", rf_we, 0);
        chk("rst_rd", rf_rd, 0);
        chk("rst_data", rf_data, 0);
        chk("rst_pc", rf_pc, 0);
        chk("rst_ready", src_ready, 2'b11);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        drive(0, 1, 32'h100, 5'd5, 1, 0, 3'b000, 32'h1234_5678, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_lat1_we", rf_we, 0);
        tick();
        chk("alu_we", rf_we, 1);
        chk("alu_rd", rf_rd, 5);
        chk("alu_data", rf_data, 32'h1234_5678);
        chk("alu_pc", rf_pc, 32'h100);
        tick();
        chk("alu_one_cycle", rf_we, 0);
        chk("alu_hold", rf_data, 32'h1234_5678);

        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 32'h400 + k, 5'd6, 1, 1, ld_f3[k], 32'h1000 + 32'(ld_off[k]), 32'h80FF_7F01);
            tick();
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            chk("load_we", rf_we, 1);
            chk($sformatf("load_data%0d", k), rf_data, ld_exp[k]);
            tick();
        end

        drive(0, 1, 32'h500, 5'd0, 1, 0, 0, 32'hDEAD, 0);
        chk("drop0_ready", src_ready, 2'b11);
        tick();
        drive(0, 1, 32'h504, 5'd7, 0, 0, 0, 32'hBEEF, 0);
        chk("drop0_busy", busy, 0);
        chk("drop1_ready", src_ready, 2'b11);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("drop1_busy", busy, 0);
        chk("drop_we_a", rf_we, 0);
        tick();
        chk("drop_we_b", rf_we, 0);
        chk("drop_busy", busy, 0);

        i0 = 0; i1 = 0; n = 0;
        for (int c = 0; c < 30; c++) begin
            drive(0, i0 < 4, 32'h200 + i0, 5'(1 + i0), 1, 0, 0, 32'hA000 + 32'(1 + i0), 0);
            drive(1, i1 < 4, 32'h300 + i1, 5'(11 + i1), 1, 0, 0, 32'hA000 + 32'(11 + i1), 0);
            a0 = src_valid[0] && src_ready[0];
            a1 = src_valid[1] && src_ready[1];
            tick();
            if (a0) i0++;
            if (a1) i1++;
            if (c < 7) chk($sformatf("rr_ready%0d", c), src_ready, rr_rdy[c]);
            if (rf_we) begin
                if (n < 8) begin
                    chk($sformatf("rr_rd%0d", n), rf_rd, rr_rd[n]);
                    chk($sformatf("rr_data%0d", n), rf_data, 32'hA000 + 32'(rr_rd[n]));
                end
                n++;
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rr_count", n, 8);
        chk("rr_idle", busy, 0);

        drive(0, 1, 32'h600, 5'd9, 1, 0, 0, 32'h1, 0);
        drive(1, 1, 32'h700, 5'd10, 1, 0, 0, 32'h2, 0);
        tick();
        drive(0, 1, 32'h604, 5'd9, 1, 0, 0, 32'h3, 0);
        drive(1, 1, 32'h704, 5'd10, 1, 0, 0, 32'h4, 0);
        tick();
        chk("mid_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_ready", src_ready, 2'b11);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", rf_data, 0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid_no_stale", {busy, rf_we}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
